// File: rtl/seg_capture_encoder_pkg.sv
// Shared segment/hex code definitions for the 7-segment capture monitor.
// Patterns are Seg[0:6] (a..g) read as a 7-bit MSB-first value, active-low.
package seg_capture_pkg;

  typedef logic [3:0] hex_digit_t;
  typedef logic [6:0] seg_pattern_t;

  localparam seg_pattern_t SEG_0     = 7'h01;
  localparam seg_pattern_t SEG_1     = 7'h4F;
  localparam seg_pattern_t SEG_2     = 7'h12;
  localparam seg_pattern_t SEG_3     = 7'h06;
  localparam seg_pattern_t SEG_4     = 7'h4C;
  localparam seg_pattern_t SEG_5     = 7'h24;
  localparam seg_pattern_t SEG_6     = 7'h20;
  localparam seg_pattern_t SEG_7     = 7'h0F;
  localparam seg_pattern_t SEG_8     = 7'h00;
  localparam seg_pattern_t SEG_9     = 7'h04;
  localparam seg_pattern_t SEG_BLANK = 7'h7F;

  localparam hex_digit_t HEX_BLANK = 4'hF;
  localparam hex_digit_t HEX_ERR   = 4'hE;

endpackage

// File: rtl/seg_capture_encoder_if.sv
// Display bus (sampled) plus captured-frame valid/ready channel.
// slave = the monitor, master = whoever drives the display and consumes frames.
interface seg_capture_encoder_if #(
  parameter int NUM_DIGITS = 4
);

  logic [0:6]              Seg;
  logic [NUM_DIGITS-1:0]   An;
  logic                    clr;
  logic [4*NUM_DIGITS-1:0] Digits;
  logic [NUM_DIGITS-1:0]   DigitErr;
  logic                    out_valid;
  logic                    out_ready;
  logic                    overrun;

  modport master (
    output Seg, An, clr, out_ready,
    input  Digits, DigitErr, out_valid, overrun
  );

  modport slave (
    input  Seg, An, clr, out_ready,
    output Digits, DigitErr, out_valid, overrun
  );

endinterface

// File: rtl/seg_pattern_encoder.sv
// Combinational decode of one active-low 7-segment pattern back to a hex value.
// Blank decodes to HEX_BLANK without error; anything unrecognised flags err.
module seg_pattern_encoder
  import seg_capture_pkg::*;
(
  input  seg_pattern_t pattern,
  output hex_digit_t   value,
  output logic         err
);

  always_comb begin
    value = HEX_ERR;
    err   = 1'b1;
    case (pattern)
      SEG_0:     begin value = 4'h0;      err = 1'b0; end
      SEG_1:     begin value = 4'h1;      err = 1'b0; end
      SEG_2:     begin value = 4'h2;      err = 1'b0; end
      SEG_3:     begin value = 4'h3;      err = 1'b0; end
      SEG_4:     begin value = 4'h4;      err = 1'b0; end
      SEG_5:     begin value = 4'h5;      err = 1'b0; end
      SEG_6:     begin value = 4'h6;      err = 1'b0; end
      SEG_7:     begin value = 4'h7;      err = 1'b0; end
      SEG_8:     begin value = 4'h8;      err = 1'b0; end
      SEG_9:     begin value = 4'h9;      err = 1'b0; end
      SEG_BLANK: begin value = HEX_BLANK; err = 1'b0; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/seg_capture_encoder.sv
// Passive monitor of a multiplexed 7-segment bus: captures each digit once it
// has settled, assembles a frame of all digits and offers it on valid/ready.
module seg_capture_encoder
  import seg_capture_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  seg_capture_encoder_if.slave bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 1);

  logic [NUM_DIGITS-1:0]   samp_an;
  seg_pattern_t            samp_seg;
  logic [CNT_W-1:0]        stable_cnt;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]   shadow_err;
  logic [NUM_DIGITS-1:0]   seen;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   digit_err_q;
  logic                    valid_q;
  logic                    overrun_q;

  logic [NUM_DIGITS-1:0]   an_low;
  logic                    an_onehot;
  logic [IDX_W-1:0]        digit_idx;
  logic                    input_same;
  logic                    capture;
  logic                    frame_done;
  logic                    accept;
  hex_digit_t              enc_value;
  logic                    enc_err;

  seg_pattern_encoder u_encoder (
    .pattern (samp_seg),
    .value   (enc_value),
    .err     (enc_err)
  );

  assign an_low     = ~samp_an;
  assign an_onehot  = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
  assign input_same = ({bus.An, bus.Seg} == {samp_an, samp_seg});
  // The counter passes CNT_HIT exactly once per stable run, giving one capture.
  assign capture    = (stable_cnt == CNT_HIT);
  assign frame_done = &seen;
  assign accept     = valid_q && bus.out_ready;

  always_comb begin
    digit_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_low[i]) digit_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_an    <= '0;
      samp_seg   <= '0;
      stable_cnt <= '0;
    end else begin
      samp_an  <= bus.An;
      samp_seg <= bus.Seg;
      if (bus.clr) begin
        stable_cnt <= '0;
      end else if (input_same && an_onehot) begin
        if (stable_cnt != CNT_MAX) stable_cnt <= stable_cnt + 1'b1;
      end else begin
        stable_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      shadow_err <= '0;
      seen       <= '0;
    end else if (bus.clr) begin
      shadow     <= '0;
      shadow_err <= '0;
      seen       <= '0;
    end else begin
      if (frame_done) seen <= '0;
      if (capture) begin
        shadow[4*int'(digit_idx) +: 4] <= enc_value;
        shadow_err[digit_idx]          <= enc_err;
        seen[digit_idx]                <= 1'b1;
      end
    end
  end

  // A dropped frame can only happen with out_ready low, so overrun set/clear never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q    <= '0;
      digit_err_q <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (frame_done) begin
        if (!valid_q || bus.out_ready) begin
          digits_q    <= shadow;
          digit_err_q <= shadow_err;
          valid_q     <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (accept) begin
        valid_q <= 1'b0;
      end
      if (accept) overrun_q <= 1'b0;
    end
  end

  assign bus.Digits    = digits_q;
  assign bus.DigitErr  = digit_err_q;
  assign bus.out_valid = valid_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_seg_capture_encoder.sv
// Directed bench for seg_capture_encoder: table of full scan frames plus
// hand-written glitch, backpressure, bad-anode, clr and reset sequences.
module tb_seg_capture_encoder;
  import seg_capture_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seg_capture_encoder_if #(.NUM_DIGITS(4)) tb_if ();

  seg_capture_encoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tb_if)
  );

  typedef struct {
    string       name;
    logic [27:0] pats;
    logic [15:0] exp_digits;
    logic [3:0]  exp_err;
  } vec_t;

  vec_t vecs[4];

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int first_valid_cyc = -1;
  int start_cyc = 0;
  logic [15:0] last_digits;
  logic [3:0]  last_err;

  // Every cycle is observed 1ns after the edge; valid frames are logged.
  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (tb_if.out_valid) begin
        if (valid_cnt == 0) first_valid_cyc = cyc;
        valid_cnt++;
        last_digits = tb_if.Digits;
        last_err    = tb_if.DigitErr;
      end
    end
  endtask

  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] pat, input int cycles);
    tb_if.An  = an;
    tb_if.Seg = pat;
    stepCycles(cycles);
  endtask

  task automatic showDigit(input int d, input logic [6:0] pat, input int cycles);
    applyStimulus(~(4'b0001 << d), pat, cycles);
  endtask

  task automatic idle(input int cycles);
    applyStimulus(4'b1111, SEG_BLANK, cycles);
  endtask

  task automatic clearMonitor();
    valid_cnt       = 0;
    first_valid_cyc = -1;
    last_digits     = '0;
    last_err        = '0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    vecs[0] = '{"scan_4321",    {SEG_4, SEG_3, SEG_2, SEG_1},          16'h4321, 4'b0000};
    vecs[1] = '{"illegal_blank", {SEG_0, SEG_0, 7'h55, SEG_BLANK},     16'h00EF, 4'b0010};
    vecs[2] = '{"scan_8765",    {SEG_8, SEG_7, SEG_6, SEG_5},          16'h8765, 4'b0000};
    vecs[3] = '{"mixed_ef09",   {7'h7E, SEG_BLANK, SEG_0, SEG_9},      16'hEF09, 4'b1000};

    rst_n           = 1'b0;
    tb_if.An        = 4'b1111;
    tb_if.Seg       = SEG_BLANK;
    tb_if.clr       = 1'b0;
    tb_if.out_ready = 1'b1;
    clearMonitor();
    stepCycles(3);
    checkOutput("reset_digits",   32'(tb_if.Digits),    32'h0);
    checkOutput("reset_err",      32'(tb_if.DigitErr),  32'h0);
    checkOutput("reset_valid",    32'(tb_if.out_valid), 32'h0);
    checkOutput("reset_overrun",  32'(tb_if.overrun),   32'h0);
    rst_n = 1'b1;
    idle(4);

    foreach (vecs[v]) begin
      clearMonitor();
      for (int d = 0; d < 4; d++) showDigit(d, vecs[v].pats[7*d +: 7], 8);
      idle(4);
      checkOutput({vecs[v].name, "_frames"}, 32'(valid_cnt),   32'd1);
      checkOutput({vecs[v].name, "_digits"}, 32'(last_digits), 32'(vecs[v].exp_digits));
      checkOutput({vecs[v].name, "_err"},    32'(last_err),    32'(vecs[v].exp_err));
    end

    $display("[TB] glitch rejection and capture latency");
    clearMonitor();
    showDigit(0, SEG_1, 8);
    showDigit(1, SEG_2, 8);
    showDigit(2, SEG_3, 8);
    showDigit(3, SEG_4, 3);
    idle(6);
    checkOutput("glitch_short_frames", 32'(valid_cnt), 32'd0);
    start_cyc = cyc;
    showDigit(3, SEG_8, 4);
    idle(4);
    checkOutput("glitch_frames",  32'(valid_cnt),   32'd1);
    checkOutput("glitch_digits",  32'(last_digits), 32'h8321);
    checkOutput("glitch_latency", 32'(first_valid_cyc - start_cyc), 32'd6);

    $display("[TB] backpressure and overrun");
    tb_if.out_ready = 1'b0;
    clearMonitor();
    showDigit(0, SEG_1, 8);
    showDigit(1, SEG_2, 8);
    showDigit(2, SEG_3, 8);
    showDigit(3, SEG_4, 8);
    idle(2);
    checkOutput("bp_first_valid",   32'(tb_if.out_valid), 32'd1);
    checkOutput("bp_first_overrun", 32'(tb_if.overrun),   32'd0);
    for (int d = 0; d < 4; d++) showDigit(d, SEG_0, 8);
    idle(2);
    checkOutput("bp_held_digits", 32'(tb_if.Digits),    32'h4321);
    checkOutput("bp_held_valid",  32'(tb_if.out_valid), 32'd1);
    checkOutput("bp_overrun_set", 32'(tb_if.overrun),   32'd1);
    tb_if.out_ready = 1'b1;
    stepCycles(1);
    checkOutput("bp_overrun_clear", 32'(tb_if.overrun),   32'd0);
    checkOutput("bp_valid_drop",    32'(tb_if.out_valid), 32'd0);

    $display("[TB] bad anodes and clr");
    clearMonitor();
    applyStimulus(4'b1111, SEG_1, 20);
    applyStimulus(4'b0011, SEG_1, 20);
    showDigit(0, SEG_1, 8);
    showDigit(1, SEG_2, 8);
    idle(4);
    checkOutput("badan_frames", 32'(valid_cnt), 32'd0);
    tb_if.clr = 1'b1;
    stepCycles(1);
    tb_if.clr = 1'b0;
    showDigit(2, SEG_3, 8);
    showDigit(3, SEG_4, 8);
    idle(4);
    checkOutput("clr_no_frame", 32'(valid_cnt), 32'd0);
    showDigit(0, SEG_5, 8);
    showDigit(1, SEG_6, 8);
    idle(4);
    checkOutput("clr_frames", 32'(valid_cnt),   32'd1);
    checkOutput("clr_digits", 32'(last_digits), 32'h4365);

    $display("[TB] asynchronous reset mid-frame");
    tb_if.out_ready = 1'b0;
    showDigit(0, SEG_1, 8);
    showDigit(1, SEG_2, 8);
    showDigit(2, SEG_3, 8);
    showDigit(3, SEG_4, 8);
    showDigit(0, SEG_0, 8);
    showDigit(1, SEG_0, 8);
    checkOutput("pre_reset_valid", 32'(tb_if.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_digits",  32'(tb_if.Digits),    32'h0);
    checkOutput("async_reset_err",     32'(tb_if.DigitErr),  32'h0);
    checkOutput("async_reset_valid",   32'(tb_if.out_valid), 32'h0);
    checkOutput("async_reset_overrun", 32'(tb_if.overrun),   32'h0);
    stepCycles(2);
    rst_n = 1'b1;
    tb_if.out_ready = 1'b1;
    clearMonitor();
    showDigit(2, SEG_3, 8);
    showDigit(3, SEG_4, 8);
    idle(4);
    checkOutput("post_reset_no_frame", 32'(valid_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seg_capture_encoder.md
Name: seg_capture_encoder

Overview:
- Passive monitor on the multiplexed 7-segment display bus: samples the active-low segment lines and active-low digit anodes.
- Waits for each digit's pattern to settle, then encodes the segment pattern back to a 4-bit value.
- Assembles one value per digit into a frame and presents it on a valid/ready output.
- Used for self-check and readback of what the display is actually showing.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits/anodes (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before capture (>=2).
- CNT_W, $clog2(STABLE_CYCLES+1), localparam, stability counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Seg  in  [0:6]  segment lines a..g, Seg[0]=a, 0=on/1=off.
- An  in  NUM_DIGITS  anode enables, active-low; An[i]=0 selects digit i.
- clr  in  1  synchronous abort of the frame being assembled.
- Digits  out  4*NUM_DIGITS  captured frame; digit i at [4i+3:4i].
- DigitErr  out  NUM_DIGITS  per-digit illegal-pattern flag for the frame on Digits.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accepts the frame when out_valid && out_ready at a rising edge.
- overrun  out  1  sticky; a completed frame was dropped because the output was still pending.

Behaviour:
- Reset (async, rst_n=0): Digits=0, DigitErr=0, out_valid=0, overrun=0; shadow frame, seen mask, sample register and stability counter cleared.
- Input stage: {An,Seg} registered every cycle. The stability counter increments while the registered value is unchanged and An is one-hot-low. It resets to 0 on any change, all-high An, or multiple low An bits, and saturates at STABLE_CYCLES.
- Capture: exactly one capture per stable run. An identical {An,Seg} present at STABLE_CYCLES consecutive edges e1..eN is captured at edge eN+1: shadow[i] and shadow_err[i] are written and seen[i] is set. A held pattern does not recapture until the run breaks.
- Re-capture of the same digit before the frame completes overwrites that digit (latest wins).
- Encoding (Seg[0:6] as 7-bit MSB-first):
  - 0x01->0, 0x4F->1, 0x12->2, 0x06->3, 0x4C->4, 0x24->5, 0x20->6, 0x0F->7, 0x00->8, 0x04->9.
  - 0x7F (blank) -> 0xF, err=0.
  - Any other pattern -> 0xE, err=1.
- Frame completion: the edge after seen becomes all-ones.
  - If out_valid==0, or out_ready==1 in that cycle: Digits/DigitErr <= shadow, out_valid <= 1, seen <= 0.
  - Else: frame dropped, overrun <= 1, seen <= 0, Digits unchanged.
- Handshake:
  - out_valid holds, with Digits/DigitErr stable, until accepted.
  - On accept, out_valid drops next edge unless a new frame loads at the same edge (then stays 1).
  - Accept clears overrun. Set and clear in the same cycle cannot occur, because a drop requires !out_ready.
- Latency: with STABLE_CYCLES=4, last digit presented from edge k -> captured at k+4 -> out_valid=1 after edge k+5.
- clr: synchronous. Clears seen, shadow and the stability counter. Does not affect out_valid, Digits or overrun. clr wins over a same-cycle capture.
- NUM_DIGITS=1: a frame is produced once per stable run, i.e. only when the displayed pattern changes.

Decomposition:
- Package seg_capture_pkg:
  - Constants SEG_0..SEG_9 and SEG_BLANK.
  - HEX_BLANK=4'hF, HEX_ERR=4'hE.
  - Function or typedef for 4-bit digit codes.
- Sub-module seg_pattern_encoder: combinational 7-bit pattern -> {value[3:0], err}, one shared instance on the registered sample.
- Top holds the sample register, stability counter, shadow/seen arrays and output/handshake logic.

Test Plan:
- Scan: An scans 0..3 with patterns 0x4F,0x12,0x06,0x4C, each held 8 cycles, out_ready=1 -> one frame, Digits=16'h4321, DigitErr=0, out_valid one cycle.
- Glitch: pattern held only 3 cycles (STABLE_CYCLES=4), then a different pattern for 4 -> only the second is captured; no capture from the short pattern.
- Illegal/blank: digit0=0x7F, digit1=0x55, others 0x01 -> Digits=16'h00EF, DigitErr=4'b0010.
- Backpressure: out_ready=0 for two full scan frames -> first frame held unchanged, overrun=1 after second completes; then out_ready=1 -> overrun=0 next edge.
- Bad anodes: An=4'b1111 or 4'b0011 for 20 cycles -> no captures, seen stays 0.
- Reset/clr: rst_n pulsed low mid-frame -> all outputs 0 immediately. clr after 2 of 4 digits captured -> frame only after all 4 digits are recaptured.
